lagarto_reset_sequencer: RTL and testbench
==========================================

// Module: lagarto_reset_sequencer
// PURPOSE
//  Multi-hart reset/boot sequencer for the Lagarto tile: generalises the single-core wake-up counter
//  and reset gate to NUM_HARTS cores. After global reset, waits WAKE_CYCLES, then releases hart resets
//  one by one STAGGER_CYCLES apart. It also serves per-hart soft-reset requests with a req/ack
//  handshake and presents a stable boot address and hart id to each core's CSR file.
// PARAMETERS
//  NUM_HARTS        4        number of cores sequenced, >=1
//  WAKE_CYCLES      32768    cycles held in reset after rst_i drops, >=1
//  STAGGER_CYCLES   16       cycles between consecutive hart releases, >=1
//  SOFT_RST_CYCLES  16       reset pulse length for a soft reset, >=1
//  BOOT_STRIDE      64'h0    boot address increment per hart index
// PORTS
//  clk_i            in   1            core clock
//  rst_i            in   1            synchronous, active-high reset
//  boot_base_i      in   64           boot address of hart 0
//  soft_rst_req_i   in   NUM_HARTS    per-hart soft-reset request (level)
//  soft_rst_ack_o   out  NUM_HARTS    per-hart one-cycle completion pulse
//  hart_rst_o       out  NUM_HARTS    active-high reset to each core
//  boot_addr_o      out  NUM_HARTS*64 per-hart boot address, hart k at [64k+:64]
//  hart_id_o        out  NUM_HARTS*64 per-hart id (=k), hart k at [64k+:64]
//  all_up_o         out  1            all harts released at least once since rst_i
// BEHAVIOUR
//  - Reset (rst_i=1, sampled at the clock edge): state S_WAKE, cnt=0, idx=0, hart_rst_o='1, soft_rst_ack_o='0,
//    all_up_o=0, boot_addr_o/hart_id_o loaded. rst_i at any time aborts any operation and restarts the sequence.
//  - Cycle 0 = first cycle with rst_i=0. Counter width = $clog2(max(WAKE,STAGGER,SOFT)+1). The counter does not wrap.
//  - S_WAKE: cnt++ each cycle. At cnt==WAKE_CYCLES-1: go to S_STAGGER with cnt=0, idx=0.
//  - S_STAGGER: when cnt==0, release hart idx (hart_rst_o[idx] is registered and drops at the next edge).
//    At cnt==STAGGER_CYCLES-1: idx++ and cnt=0. After the idx==NUM_HARTS-1 release, go to S_RUN.
//    Result: hart_rst_o[k] first reads 0 in cycle WAKE_CYCLES+k*STAGGER_CYCLES+1.
//    With NUM_HARTS=1, go to S_RUN straight after the single release.
//  - S_RUN: all_up_o=1 (registered, one cycle after the last release). It stays 1 until rst_i.
//  - Soft reset, accepted only in S_RUN with no soft reset active:
//      - Pick the lowest k with soft_rst_req_i[k]=1 and armed[k]=1.
//      - Assert hart_rst_o[k] for exactly SOFT_RST_CYCLES cycles, then deassert it.
//      - In the deassert cycle, pulse soft_rst_ack_o[k] for 1 cycle and clear armed[k].
//      - armed[k] sets again only when soft_rst_req_i[k]=0 is sampled. A held request is never served twice.
//      - Other pending requests wait and are served in index order, one at a time.
//      - Requests raised in S_WAKE/S_STAGGER are held pending until S_RUN.
//      - Harts not being soft-reset are unaffected.
//  - boot_addr_o[k] = boot_base_i + k*BOOT_STRIDE (64-bit add, wrap modulo 2^64).
//    It is re-registered every cycle that hart_rst_o[k]=1 and frozen while hart k runs.
//    hart_id_o[k] = k, constant.
//  - soft_rst_ack_o is never high while hart_rst_o of the same hart is high.
// CONFIGURATION
//  LAGARTO_RSTSEQ_DBG_HOLD_EN defined:
//    - Adds port dbg_hold_i (in, NUM_HARTS).
//    - A release due for hart idx with dbg_hold_i[idx]=1 is deferred: S_STAGGER stalls with cnt held at 0 until the hold drops.
//    - In S_RUN, a hart whose soft reset ends while held stays in reset; its ack is issued on the cycle it is released.
//  LAGARTO_RSTSEQ_DBG_HOLD_EN undefined: the port is absent, releases never stall, and the timing is as above.
// TESTING (NUM_HARTS=4, WAKE=16, STAGGER=4, SOFT=8, base=64'h8000_0000, stride=64'h1000)
//  - Power-up: rst_i 1->0 at cycle 0.
//    -> hart_rst_o goes 1111 -> 1110@17, 1100@21, 1000@25, 0000@29; all_up_o=1@30.
//    -> boot_addr_o[3]=64'h8000_3000 and hart_id_o[2]=2.
//  - Soft reset: req[2]=1 in S_RUN.
//    -> hart_rst_o[2]=1 for 8 cycles, ack[2] pulses 1 cycle, other harts stay 0.
//    -> req[2] held high afterwards gives no second reset.
//  - Contention: req[1] and req[3] rise in the same cycle.
//    -> hart 1 is served first; hart 3 reset starts after ack[1]; two ack pulses in total.
//  - Early request: req[0]=1 at cycle 5 (S_WAKE).
//    -> normal stagger, then hart 0 soft reset begins in the first S_RUN cycle.
//  - Reset mid-op: rst_i=1 during the hart-2 stagger or during a soft reset.
//    -> hart_rst_o=1111, ack=0, all_up_o=0 next cycle; full sequence re-runs.
//  - DBG_HOLD_EN: dbg_hold_i[1]=1 until cycle 40.
//    -> hart 1 is released @41, harts 2/3 @45/@49.
//    -> With the macro undefined, the timing is identical to the power-up test.

Source files
------------

// File: rtl/lagarto_reset_sequencer.sv
// -----------------------------------------------------------------------------
// lagarto_reset_sequencer
//   Multi-hart reset/boot sequencer for the Lagarto tile. After rst_i drops,
//   all harts are held in reset for WAKE_CYCLES. The harts are then released
//   one at a time, STAGGER_CYCLES apart. After every hart is up, per-hart
//   soft-reset requests are served one at a time, lowest index first, with a
//   one-cycle ack pulse. Each hart also gets a boot address and a hart id.
//
// Ports
//   clk_i           core clock
//   rst_i           synchronous, active-high reset (restarts the whole sequence)
//   boot_base_i     boot address of hart 0
//   soft_rst_req_i  per-hart soft-reset request (level)
//   soft_rst_ack_o  per-hart one-cycle completion pulse
//   hart_rst_o      active-high reset to each core
//   boot_addr_o     hart k at [64k+:64] = boot_base_i + k*BOOT_STRIDE
//   hart_id_o       hart k at [64k+:64] = k
//   all_up_o        every hart released at least once since rst_i
//   dbg_hold_i      (only with LAGARTO_RSTSEQ_DBG_HOLD_EN) per-hart release hold
//
// Configuration macro
//   LAGARTO_RSTSEQ_DBG_HOLD_EN : adds dbg_hold_i. A staggered release is
//   deferred while its hart is held. A soft reset that ends while its hart is
//   held keeps that hart in reset, and the ack is issued on the release cycle.
// -----------------------------------------------------------------------------
module lagarto_reset_sequencer #(
   parameter int unsigned NUM_HARTS       = 4,
   parameter int unsigned WAKE_CYCLES     = 32768,
   parameter int unsigned STAGGER_CYCLES  = 16,
   parameter int unsigned SOFT_RST_CYCLES = 16,
   parameter logic [63:0] BOOT_STRIDE     = 64'h0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [63:0]               boot_base_i,
   input  logic [NUM_HARTS-1:0]      soft_rst_req_i,
`ifdef LAGARTO_RSTSEQ_DBG_HOLD_EN
   input  logic [NUM_HARTS-1:0]      dbg_hold_i,
`endif
   output logic [NUM_HARTS-1:0]      soft_rst_ack_o,
   output logic [NUM_HARTS-1:0]      hart_rst_o,
   output logic [NUM_HARTS*64-1:0]   boot_addr_o,
   output logic [NUM_HARTS*64-1:0]   hart_id_o,
   output logic                      all_up_o
);

   localparam int unsigned MAX_AB = (WAKE_CYCLES > STAGGER_CYCLES) ? WAKE_CYCLES : STAGGER_CYCLES;
   localparam int unsigned MAX_C  = (MAX_AB > SOFT_RST_CYCLES) ? MAX_AB : SOFT_RST_CYCLES;
   localparam int unsigned CNT_W  = $clog2(MAX_C + 1);
   localparam int unsigned IDX_W  = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_RST_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_HART = IDX_W'(NUM_HARTS - 1);

   typedef enum logic [1:0] {S_WAKE, S_STAGGER, S_RUN} state_t;

   state_t                r_state,    w_state_nxt;
   logic [CNT_W-1:0]      r_cnt,      w_cnt_nxt;
   logic [IDX_W-1:0]      r_idx,      w_idx_nxt;
   logic [NUM_HARTS-1:0]  r_hart_rst, w_hart_rst_nxt;
   logic [NUM_HARTS-1:0]  r_ack,      w_ack_nxt;
   logic [NUM_HARTS-1:0]  r_armed,    w_armed_nxt;
   logic                  r_sr_act,   w_sr_act_nxt;
   logic [IDX_W-1:0]      r_sr_idx,   w_sr_idx_nxt;
   logic                  r_all_up,   w_all_up_nxt;

   logic [NUM_HARTS-1:0]  w_hold;
   logic [NUM_HARTS-1:0]  w_pend;
   logic [IDX_W-1:0]      w_pick;

`ifdef LAGARTO_RSTSEQ_DBG_HOLD_EN
   assign w_hold = dbg_hold_i;
`else
   assign w_hold = '0;
`endif

   // A request is eligible only while armed; armed drops when the hart's
   // soft reset completes and returns once the request is seen low, so a
   // held-high request is served exactly once.
   assign w_pend = soft_rst_req_i & r_armed;

   // Lowest eligible index wins.
   always_comb begin
      w_pick = '0;
      for (int k = NUM_HARTS - 1; k >= 0; k--) begin
         if (w_pend[k]) w_pick = IDX_W'(k);
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_idx_nxt      = r_idx;
      w_hart_rst_nxt = r_hart_rst;
      w_ack_nxt      = '0;
      w_armed_nxt    = r_armed | ~soft_rst_req_i;
      w_sr_act_nxt   = r_sr_act;
      w_sr_idx_nxt   = r_sr_idx;
      w_all_up_nxt   = r_all_up;

      case (r_state)
         S_WAKE: begin
            if (r_cnt == WAKE_LAST) begin
               w_state_nxt = S_STAGGER;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end

         S_STAGGER: begin
            // Release happens in the cnt==0 slot; a held hart freezes the
            // slot so the remaining spacing is preserved after the hold.
            if (r_cnt == '0 && w_hold[r_idx]) begin
               w_cnt_nxt = '0;
            end else begin
               if (r_cnt == '0) w_hart_rst_nxt[r_idx] = 1'b0;
               if (r_cnt == '0 && r_idx == LAST_HART) begin
                  w_state_nxt = S_RUN;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == STAG_LAST) begin
                  w_idx_nxt = r_idx + 1'b1;
                  w_cnt_nxt = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end

         S_RUN: begin
            w_all_up_nxt = 1'b1;
            if (r_sr_act) begin
               if (r_cnt == SOFT_LAST) begin
                  // Counter parks at the last value while the hart is held.
                  if (!w_hold[r_sr_idx]) begin
                     w_hart_rst_nxt[r_sr_idx] = 1'b0;
                     w_ack_nxt[r_sr_idx]      = 1'b1;
                     w_armed_nxt[r_sr_idx]    = 1'b0;
                     w_sr_act_nxt             = 1'b0;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end else if (|w_pend) begin
               w_sr_act_nxt           = 1'b1;
               w_sr_idx_nxt           = w_pick;
               w_cnt_nxt              = '0;
               w_hart_rst_nxt[w_pick] = 1'b1;
            end
         end

         default: begin
            w_state_nxt = S_WAKE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_WAKE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_hart_rst <= '1;
         r_ack      <= '0;
         r_armed    <= '1;
         r_sr_act   <= 1'b0;
         r_sr_idx   <= '0;
         r_all_up   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_hart_rst <= w_hart_rst_nxt;
         r_ack      <= w_ack_nxt;
         r_armed    <= w_armed_nxt;
         r_sr_act   <= w_sr_act_nxt;
         r_sr_idx   <= w_sr_idx_nxt;
         r_all_up   <= w_all_up_nxt;
      end
   end

   // Boot address tracks boot_base_i while the hart sits in reset and is
   // frozen while the hart runs, so a core never sees it move under it.
   for (genvar k = 0; k < NUM_HARTS; k++) begin : g_hart
      localparam logic [63:0] OFFS = 64'(k) * BOOT_STRIDE;
      logic [63:0] r_boot;

      always_ff @(posedge clk_i) begin
         if (rst_i || r_hart_rst[k]) r_boot <= boot_base_i + OFFS;
      end

      assign boot_addr_o[64*k +: 64] = r_boot;
      assign hart_id_o[64*k +: 64]   = 64'(k);
   end

   assign hart_rst_o     = r_hart_rst;
   assign soft_rst_ack_o = r_ack;
   assign all_up_o       = r_all_up;

endmodule

// File: tb/tb_lagarto_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lagarto_reset_sequencer
//   Self-checking bench. The reference model works in terms of the cycle index
//   since reset release: hart k is in reset before cycle WAKE+k*STAGGER+1, and
//   all_up starts at cycle WAKE+(N-1)*STAGGER+2. A soft reset is tracked as an
//   (owner, end cycle) pair, plus a per-hart armed flag.
// -----------------------------------------------------------------------------
module tb_lagarto_reset_sequencer;

   localparam int N    = 4;
   localparam int WAKE = 16;
   localparam int STAG = 4;
   localparam int SOFT = 8;
   localparam logic [63:0] STRIDE = 64'h1000;
   localparam logic [63:0] BASE0  = 64'h8000_0000;
   localparam int RUN  = WAKE + (N - 1) * STAG + 1;   // first S_RUN cycle

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [63:0]        base = BASE0;
   logic [N-1:0]       req = '0;
   logic [N-1:0]       ack, hart_rst;
   logic [N*64-1:0]    boot_addr, hart_id;
   logic               all_up;
`ifdef LAGARTO_RSTSEQ_DBG_HOLD_EN
   logic [N-1:0]       dbg_hold = '0;
`endif

   int n_chk = 0;
   int n_err = 0;

   // model state
   int           m_t;
   bit           m_busy;
   int           m_who, m_end;
   logic [N-1:0] m_armed;
   logic [63:0]  m_boot [N];
   // expectations for the current cycle
   logic [N-1:0]    e_rst, e_ack;
   logic            e_up;
   logic [N*64-1:0] e_boot;

   lagarto_reset_sequencer #(
      .NUM_HARTS(N), .WAKE_CYCLES(WAKE), .STAGGER_CYCLES(STAG),
      .SOFT_RST_CYCLES(SOFT), .BOOT_STRIDE(STRIDE)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .boot_base_i(base),
      .soft_rst_req_i(req),
`ifdef LAGARTO_RSTSEQ_DBG_HOLD_EN
      .dbg_hold_i(dbg_hold),
`endif
      .soft_rst_ack_o(ack),
      .hart_rst_o(hart_rst),
      .boot_addr_o(boot_addr),
      .hart_id_o(hart_id),
      .all_up_o(all_up)
   );

   always #5 clk = ~clk;

   // Apply inputs for this cycle and derive expected outputs from the model.
   task automatic set_in(input logic r, input logic [N-1:0] q, input logic [63:0] b);
      rst  = r;
      req  = q;
      base = b;
      for (int k = 0; k < N; k++) begin
         e_rst[k] = (m_t < WAKE + k * STAG + 1) || (m_busy && m_who == k && m_t < m_end);
         e_ack[k] = m_busy && m_who == k && m_t == m_end;
         e_boot[64*k +: 64] = m_boot[k];
      end
      e_up = (m_t >= RUN + 1);
   endtask

   // Advance the model across the clock edge, then move to mid-cycle.
   task automatic step();
      int pick;
      bit active;
      pick   = -1;
      active = m_busy && m_t < m_end;
      for (int k = 0; k < N; k++)
         if (rst || e_rst[k]) m_boot[k] = base + 64'(k) * STRIDE;
      if (rst) begin
         m_t     = 0;
         m_busy  = 0;
         m_armed = '1;
      end else begin
         if (!active && m_t >= RUN)
            for (int k = N - 1; k >= 0; k--)
               if (req[k] && m_armed[k]) pick = k;
         for (int k = 0; k < N; k++) begin
            if (active && m_t == m_end - 1 && k == m_who) m_armed[k] = 1'b0;
            else if (!req[k]) m_armed[k] = 1'b1;
         end
         if (pick >= 0) begin
            m_busy = 1;
            m_who  = pick;
            m_end  = m_t + 1 + SOFT;
         end
         m_t++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         set_in(1'b1, '0, BASE0);
         step();
      end
      set_in(1'b1, '0, BASE0);
      n_chk++;
      if ({hart_rst, ack, all_up} !== {4'hF, 4'h0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_state got rst=%b ack=%b up=%b want 1111/0000/0", hart_rst, ack, all_up);
      end
      for (int k = 0; k < N; k++) begin
         n_chk++;
         if (hart_id[64*k +: 64] !== 64'(k)) begin
            n_err++;
            $display("FAIL hart_id[%0d] got %h want %h", k, hart_id[64*k +: 64], 64'(k));
         end
      end
      step();
   endtask

   task automatic test_powerup();
      int first0 [N];
      int up_at;
      for (int k = 0; k < N; k++) first0[k] = -1;
      up_at = -1;
      for (int c = 0; c < 45; c++) begin
         set_in(1'b0, '0, (m_t < 30) ? BASE0 : {$urandom, $urandom});
         n_chk++;
         if ({hart_rst, ack, all_up} !== {e_rst, e_ack, e_up}) begin
            n_err++;
            $display("FAIL powerup t=%0d got rst=%b ack=%b up=%b want rst=%b ack=%b up=%b",
                     m_t, hart_rst, ack, all_up, e_rst, e_ack, e_up);
         end
         n_chk++;
         if (boot_addr !== e_boot) begin
            n_err++;
            $display("FAIL powerup_boot t=%0d got %h want %h", m_t, boot_addr, e_boot);
         end
         for (int k = 0; k < N; k++)
            if (first0[k] < 0 && hart_rst[k] === 1'b0) first0[k] = m_t;
         if (up_at < 0 && all_up === 1'b1) up_at = m_t;
         step();
      end
      for (int k = 0; k < N; k++) begin
         n_chk++;
         if (first0[k] != WAKE + k * STAG + 1) begin
            n_err++;
            $display("FAIL release_cycle[%0d] got %0d want %0d", k, first0[k], WAKE + k * STAG + 1);
         end
      end
      n_chk++;
      if (up_at != 30) begin
         n_err++;
         $display("FAIL all_up_cycle got %0d want 30", up_at);
      end
      n_chk++;
      if (boot_addr[64*3 +: 64] !== 64'h8000_3000) begin
         n_err++;
         $display("FAIL boot_addr3_frozen got %h want 0000000080003000", boot_addr[64*3 +: 64]);
      end
   endtask

   task automatic test_soft_reset();
      int hi2, acks2;
      hi2 = 0;
      acks2 = 0;
      for (int c = 0; c < 40; c++) begin
         set_in(1'b0, (c < 32) ? 4'b0100 : 4'b0000, {$urandom, $urandom});
         n_chk++;
         if ({hart_rst, ack, all_up} !== {e_rst, e_ack, e_up}) begin
            n_err++;
            $display("FAIL soft t=%0d got rst=%b ack=%b up=%b want rst=%b ack=%b up=%b",
                     m_t, hart_rst, ack, all_up, e_rst, e_ack, e_up);
         end
         n_chk++;
         if (boot_addr !== e_boot) begin
            n_err++;
            $display("FAIL soft_boot t=%0d got %h want %h", m_t, boot_addr, e_boot);
         end
         if (hart_rst[2] === 1'b1) hi2++;
         if (ack[2] === 1'b1) acks2++;
         step();
      end
      n_chk++;
      if (hi2 != SOFT) begin
         n_err++;
         $display("FAIL soft_len got %0d cycles want %0d", hi2, SOFT);
      end
      n_chk++;
      if (acks2 != 1) begin
         n_err++;
         $display("FAIL soft_ack_count got %0d want 1", acks2);
      end
   endtask

   task automatic test_contention();
      int nacks, first_ack, ack1_c, rise3_c;
      nacks = 0;
      first_ack = -1;
      ack1_c = -1;
      rise3_c = -1;
      for (int c = 0; c < 40; c++) begin
         set_in(1'b0, (c < 35) ? 4'b1010 : 4'b0000, BASE0);
         n_chk++;
         if ({hart_rst, ack, all_up} !== {e_rst, e_ack, e_up}) begin
            n_err++;
            $display("FAIL contention t=%0d got rst=%b ack=%b up=%b want rst=%b ack=%b up=%b",
                     m_t, hart_rst, ack, all_up, e_rst, e_ack, e_up);
         end
         for (int k = 0; k < N; k++)
            if (ack[k] === 1'b1) begin
               nacks++;
               if (first_ack < 0) first_ack = k;
            end
         if (ack1_c < 0 && ack[1] === 1'b1) ack1_c = c;
         if (rise3_c < 0 && hart_rst[3] === 1'b1) rise3_c = c;
         step();
      end
      n_chk++;
      if (nacks != 2 || first_ack != 1) begin
         n_err++;
         $display("FAIL contention_order got acks=%0d first=%0d want acks=2 first=1", nacks, first_ack);
      end
      n_chk++;
      if (ack1_c < 0 || rise3_c != ack1_c + 1) begin
         n_err++;
         $display("FAIL contention_hart3_start got %0d want %0d", rise3_c, ack1_c + 1);
      end
   endtask

   task automatic test_early_request();
      int rise0;
      rise0 = -1;
      set_in(1'b1, '0, BASE0);
      step();
      for (int c = 0; c < 50; c++) begin
         set_in(1'b0, (m_t >= 5) ? 4'b0001 : 4'b0000, BASE0);
         n_chk++;
         if ({hart_rst, ack, all_up} !== {e_rst, e_ack, e_up}) begin
            n_err++;
            $display("FAIL early t=%0d got rst=%b ack=%b up=%b want rst=%b ack=%b up=%b",
                     m_t, hart_rst, ack, all_up, e_rst, e_ack, e_up);
         end
         if (rise0 < 0 && m_t > WAKE + 1 && hart_rst[0] === 1'b1) rise0 = m_t;
         step();
      end
      n_chk++;
      if (rise0 != RUN + 1) begin
         n_err++;
         $display("FAIL early_soft_start got %0d want %0d", rise0, RUN + 1);
      end
   endtask

   task automatic test_reset_mid();
      set_in(1'b1, '0, BASE0);
      step();
      // rst at cycle 22 (hart-2 stagger window), then again mid soft reset
      for (int c = 0; c < 90; c++) begin
         set_in((c == 22 || c == 62) ? 1'b1 : 1'b0, (c >= 58) ? 4'b0010 : 4'b0000, {$urandom, $urandom});
         n_chk++;
         if ({hart_rst, ack, all_up} !== {e_rst, e_ack, e_up}) begin
            n_err++;
            $display("FAIL reset_mid c=%0d got rst=%b ack=%b up=%b want rst=%b ack=%b up=%b",
                     c, hart_rst, ack, all_up, e_rst, e_ack, e_up);
         end
         n_chk++;
         if (boot_addr !== e_boot) begin
            n_err++;
            $display("FAIL reset_mid_boot c=%0d got %h want %h", c, boot_addr, e_boot);
         end
         if (c == 23 || c == 63) begin
            n_chk++;
            if ({hart_rst, ack, all_up} !== {4'hF, 4'h0, 1'b0}) begin
               n_err++;
               $display("FAIL reset_mid_state c=%0d got rst=%b ack=%b up=%b want 1111/0000/0",
                        c, hart_rst, ack, all_up);
            end
         end
         step();
      end
   endtask

   task automatic test_random();
      logic [N-1:0] q;
      q = '0;
      for (int c = 0; c < 800; c++) begin
         for (int k = 0; k < N; k++)
            if ($urandom_range(11, 0) == 0) q[k] = ~q[k];
         set_in(($urandom_range(299, 0) == 0) ? 1'b1 : 1'b0, q, {$urandom, $urandom});
         n_chk++;
         if ({hart_rst, ack, all_up} !== {e_rst, e_ack, e_up}) begin
            n_err++;
            $display("FAIL random c=%0d t=%0d got rst=%b ack=%b up=%b want rst=%b ack=%b up=%b",
                     c, m_t, hart_rst, ack, all_up, e_rst, e_ack, e_up);
         end
         n_chk++;
         if (boot_addr !== e_boot) begin
            n_err++;
            $display("FAIL random_boot c=%0d got %h want %h", c, boot_addr, e_boot);
         end
         n_chk++;
         if ((ack & hart_rst) !== '0) begin
            n_err++;
            $display("FAIL ack_while_rst c=%0d got ack=%b rst=%b want no overlap", c, ack, hart_rst);
         end
         step();
      end
   endtask

`ifdef LAGARTO_RSTSEQ_DBG_HOLD_EN
   task automatic test_dbg_hold();
      int first0 [N];
      int want [N];
      want = '{17, 41, 45, 49};
      for (int k = 0; k < N; k++) first0[k] = -1;
      set_in(1'b1, '0, BASE0);
      step();
      for (int c = 0; c < 55; c++) begin
         dbg_hold = (m_t < 40) ? 4'b0010 : 4'b0000;
         set_in(1'b0, '0, BASE0);
         for (int k = 0; k < N; k++)
            if (first0[k] < 0 && hart_rst[k] === 1'b0) first0[k] = m_t;
         step();
      end
      dbg_hold = '0;
      for (int k = 0; k < N; k++) begin
         n_chk++;
         if (first0[k] != want[k]) begin
            n_err++;
            $display("FAIL dbg_hold_release[%0d] got %0d want %0d", k, first0[k], want[k]);
         end
      end
   endtask
`endif

   initial begin
      m_t     = 0;
      m_busy  = 0;
      m_who   = 0;
      m_end   = 0;
      m_armed = '1;
      for (int k = 0; k < N; k++) m_boot[k] = BASE0 + 64'(k) * STRIDE;
      @(posedge clk);
      #1;
      test_reset();
      test_powerup();
      test_soft_reset();
      test_contention();
      test_early_request();
      test_reset_mid();
      test_random();
`ifdef LAGARTO_RSTSEQ_DBG_HOLD_EN
      test_dbg_hold();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
